// File: rtl/cgra_input_aligner.sv
// Lane FIFO: power-of-two circular buffer, pointers one bit wider than the address.
// Latency: a pushed word is visible at head on the cycle after the push edge.
// Backpressure: push while full is ignored (the caller flags the drop); pop while empty is ignored.
//   Ports: clk/rst, push + wdata (write side), pop (read side), head/full/empty (status).
module cgra_input_aligner_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Same index with opposite lap bit means the writer is a whole lap ahead.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full && !rst) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end
endmodule

// Aligns four skewed word lanes into 4-word frames for the CGRA input port.
// Latency: words complete on all lanes at edge E -> out_valid high after edge E+1; 1 frame/cycle sustained.
// Backpressure: out_ready low holds the frame register; lanes buffer FIFO_DEPTH words, further words drop and set overflow.
//   Ports: clk/rst; in_channel{1,2}_data{1,2}[_valid] = lanes 0..3; clear_flags;
//   out_valid/out_ready/out_data frame handshake (lane0 in LSBs); overflow per lane; frame_count.
module cgra_input_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_channel1_data1_valid,
    input  logic [DATA_WIDTH-1:0]     in_channel1_data1,
    input  logic                      in_channel1_data2_valid,
    input  logic [DATA_WIDTH-1:0]     in_channel1_data2,
    input  logic                      in_channel2_data1_valid,
    input  logic [DATA_WIDTH-1:0]     in_channel2_data1,
    input  logic                      in_channel2_data2_valid,
    input  logic [DATA_WIDTH-1:0]     in_channel2_data2,
    input  logic                      clear_flags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*DATA_WIDTH-1:0]   out_data,
    output logic [3:0]                overflow,
    output logic [FCNT_WIDTH-1:0]     frame_count
);
    logic [3:0]            lane_vld;
    logic [DATA_WIDTH-1:0] lane_dat  [4];
    logic [DATA_WIDTH-1:0] lane_head [4];
    logic [3:0]            lane_full;
    logic [3:0]            lane_empty;
    logic [3:0]            lane_drop;
    logic                  load;
    logic                  xfer;

    assign lane_vld    = {in_channel2_data2_valid, in_channel2_data1_valid,
                          in_channel1_data2_valid, in_channel1_data1_valid};
    assign lane_dat[0] = in_channel1_data1;
    assign lane_dat[1] = in_channel1_data2;
    assign lane_dat[2] = in_channel2_data1;
    assign lane_dat[3] = in_channel2_data2;

    // Fullness is taken before this edge's pop, so a simultaneous frame load
    // never makes room for a word arriving on the same edge.
    assign lane_drop = lane_vld & lane_full;

    // The frame register refills whenever it is empty or being drained this edge.
    assign xfer = out_valid && out_ready;
    assign load = (lane_empty == 4'b0000) && (!out_valid || out_ready);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        cgra_input_aligner_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (lane_vld[i]),
            .wdata (lane_dat[i]),
            .pop   (load),
            .head  (lane_head[i]),
            .full  (lane_full[i]),
            .empty (lane_empty[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            overflow    <= 4'b0000;
            frame_count <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= {lane_head[3], lane_head[2], lane_head[1], lane_head[0]};
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (xfer) begin
                frame_count <= frame_count + 1'b1;
            end
            // A drop on the clearing edge still leaves its flag set.
            overflow <= (clear_flags ? 4'b0000 : overflow) | lane_drop;
        end
    end
endmodule

// File: tb/tb_cgra_input_aligner.sv
module tb_cgra_input_aligner;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int FW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    vld = '0;
    logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic          clear_flags = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [4*DW-1:0] out_data;
    logic [3:0]    overflow;
    logic [FW-1:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: one queue per lane plus the frame being offered.
    logic [DW-1:0]   mq [4][$];
    bit              m_vld = 0;
    logic [4*DW-1:0] m_dat = '0;
    logic [3:0]      m_ovf = '0;
    int              m_frames = 0;

    always #5 clk = ~clk;

    cgra_input_aligner #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .FCNT_WIDTH (FW)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_channel1_data1_valid (vld[0]),
        .in_channel1_data1       (d0),
        .in_channel1_data2_valid (vld[1]),
        .in_channel1_data2       (d1),
        .in_channel2_data1_valid (vld[2]),
        .in_channel2_data1       (d2),
        .in_channel2_data2_valid (vld[3]),
        .in_channel2_data2       (d3),
        .clear_flags             (clear_flags),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .overflow                (overflow),
        .frame_count             (frame_count)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] frame4(input logic [DW-1:0] a, b, c, e);
        return {e, c, b, a};
    endfunction

    // Advance the reference by one clock edge using the inputs present at that edge.
    task automatic model_step(input logic [3:0] v, input logic [127:0] din,
                              input logic rdy, input logic clr, input logic r);
        bit         all_have;
        bit         take;
        bit         pre_full [4];
        logic [3:0] drop;
        if (r) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_vld = 0;
            m_dat = '0;
            m_ovf = '0;
            m_frames = 0;
        end else begin
            drop = '0;
            all_have = 1;
            for (int i = 0; i < 4; i++) begin
                pre_full[i] = (mq[i].size() >= DEPTH);
                if (mq[i].size() == 0) all_have = 0;
            end
            take = all_have && (!m_vld || rdy);
            if (m_vld && rdy) m_frames++;
            if (take) begin
                for (int i = 0; i < 4; i++) m_dat[i*DW +: DW] = mq[i].pop_front();
                m_vld = 1;
            end else if (m_vld && rdy) begin
                m_vld = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (v[i]) begin
                    if (pre_full[i]) drop[i] = 1'b1;
                    else mq[i].push_back(din[i*DW +: DW]);
                end
            end
            m_ovf = (clr ? 4'b0000 : m_ovf) | drop;
        end
    endtask

    task automatic cycle(input logic [3:0] v, input logic [DW-1:0] a, b, c, e,
                         input logic rdy, input logic clr, input logic r);
        vld = v; d0 = a; d1 = b; d2 = c; d3 = e;
        out_ready = rdy; clear_flags = clr; rst = r;
        @(posedge clk);
        model_step(v, frame4(a, b, c, e), rdy, clr, r);
        #1;
        check_val("out_valid", out_valid, m_vld);
        if (m_vld) check_val("out_data", out_data, m_dat);
        check_val("overflow", overflow, m_ovf);
        check_val("frame_count", frame_count, m_frames % (1 << FW));
    endtask

    task automatic idle(input logic rdy);
        cycle(4'b0000, 0, 0, 0, 0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset with random inputs
        for (int i = 0; i < 3; i++)
            cycle(4'($urandom), $urandom, $urandom, $urandom, $urandom, 1'b1, 1'($urandom), 1'b1);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_fcnt", frame_count, 0);

        // 2: single frame, one edge latency
        cycle(4'hF, 1, 2, 3, 4, 1'b1, 1'b0, 1'b0);
        check_val("t2_not_yet", out_valid, 0);
        idle(1'b1);
        check_val("t2_valid", out_valid, 1);
        check_val("t2_data", out_data, frame4(1, 2, 3, 4));
        idle(1'b1);
        check_val("t2_one_cycle", out_valid, 0);
        check_val("t2_fcnt", frame_count, 1);

        // 3: skewed lanes
        cycle(4'b0001, 32'hA, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        check_val("t3_wait0", out_valid, 0);
        idle(1'b1);
        idle(1'b1);
        check_val("t3_wait2", out_valid, 0);
        cycle(4'b1110, 0, 32'hB, 32'hC, 32'hD, 1'b1, 1'b0, 1'b0);
        check_val("t3_wait3", out_valid, 0);
        idle(1'b1);
        check_val("t3_valid", out_valid, 1);
        check_val("t3_data", out_data, frame4(32'hA, 32'hB, 32'hC, 32'hD));
        idle(1'b1);

        // 4: overflow with output stalled, then drain
        for (int k = 0; k < 18; k++) cycle(4'hF, k, k, k, k, 1'b0, 1'b0, 1'b0);
        check_val("t4_ovf", overflow, 4'hF);
        for (int k = 0; k < 17; k++) begin
            check_val("t4_frame_vld", out_valid, 1);
            check_val("t4_frame", out_data, frame4(k, k, k, k));
            idle(1'b1);
        end
        check_val("t4_drained", out_valid, 0);
        cycle(4'b0000, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        check_val("t4_clear", overflow, 0);

        // 5: counter wrap with out_ready toggling
        cycle(4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 17; k++) cycle(4'hF, k, k, k, k, 1'b0, 1'b0, 1'b0);
        check_val("t5_no_drop", overflow, 0);
        for (int j = 0; j < 17; j++) begin
            idle(1'b1);
            idle(1'b0);
            if (j < 16) check_val("t5_stall_hold", out_data, frame4(j + 1, j + 1, j + 1, j + 1));
        end
        check_val("t5_fcnt_wrap", frame_count, 1);
        check_val("t5_empty", out_valid, 0);

        // 6: reset discards buffered frames
        for (int k = 0; k < 8; k++) cycle(4'hF, k, k, k, k, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
        check_val("t6_flush", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            check_val("t6_no_stale", out_valid, 0);
        end
        check_val("t6_fcnt", frame_count, 0);

        // Random traffic, biased so lanes fill, skew and occasionally overflow.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] v;
            for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 99) < 55);
            cycle(v, $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 999) < 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
